// File: rtl/hc4_operand_stack_pkg.sv
// hc4_operand_stack_pkg: shared op encodings and default sizing for the HC4 operand stack.
package hc4_operand_stack_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;
  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_DUP, OP_SWAP, OP_REPL, OP_POPREPL, OP_RSVD
  } op_e;
endpackage

// File: rtl/hc4_operand_stack_if.sv
// hc4_operand_stack_if: decoder-side op bundle and stack status outputs.
interface hc4_operand_stack_if
  import hc4_operand_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);
  op_e              op;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] level_a;
  logic [WIDTH-1:0] level_b;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  modport master (output op, din, clr_err, input level_a, level_b, count, empty, full, ovf, unf);
  modport slave  (input op, din, clr_err, output level_a, level_b, count, empty, full, ovf, unf);
endinterface

// File: rtl/hc4_operand_stack.sv
// hc4_operand_stack: DEPTH x WIDTH operand stack executing one decoder op per clock with sticky fault flags.
module hc4_operand_stack
  import hc4_operand_stack_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter bit SHIFT_MODE = 1'b1
) (
  input logic clk,
  input logic Reset,
  hc4_operand_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [WIDTH-1:0] stk [DEPTH];
  logic [WIDTH-1:0] nxt [DEPTH];
  logic [CW-1:0] cnt, nxt_cnt, need;
  logic [WIDTH-1:0] push_val;
  logic ovf, unf, full, grow, shrink, unf_set, ovf_set, en;
  assign full = cnt == FULL_CNT;
  always_comb begin
    grow     = bus.op == OP_PUSH || bus.op == OP_DUP;
    shrink   = bus.op == OP_POP || bus.op == OP_POPREPL;
    need     = (bus.op == OP_SWAP || bus.op == OP_POPREPL) ? CW'(2) :
               (bus.op == OP_POP || bus.op == OP_DUP || bus.op == OP_REPL) ? CW'(1) : '0;
    unf_set  = cnt < need;
    ovf_set  = grow && full && !SHIFT_MODE && !unf_set;
    en       = bus.op != OP_NOP && bus.op != OP_RSVD && !unf_set && !ovf_set;
    push_val = bus.op == OP_DUP ? stk[0] : bus.din;
    nxt_cnt  = !en ? cnt : grow ? (full ? cnt : cnt + 1'b1) : shrink ? cnt - 1'b1 : cnt;
  end
  // above: value entering a slot on a push; below: value entering on a pop (zero at the bottom)
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [WIDTH-1:0] above, below, swp;
    if (i == 0) begin : g_top
      assign above = push_val;
      assign swp   = stk[1];
    end else begin : g_mid
      assign above = stk[i-1];
      assign swp   = i == 1 ? stk[0] : stk[i];
    end
    if (i == DEPTH - 1) begin : g_bot
      assign below = '0;
    end else begin : g_up
      assign below = stk[i+1];
    end
    assign nxt[i] = !en ? stk[i] :
                    grow ? above :
                    bus.op == OP_POP ? below :
                    bus.op == OP_SWAP ? swp :
                    bus.op == OP_REPL ? (i == 0 ? bus.din : stk[i]) :
                    bus.op == OP_POPREPL ? (i == 0 ? bus.din : below) : stk[i];
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      stk <= '{default: '0};
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      stk <= nxt;
      cnt <= nxt_cnt;
      ovf <= ovf_set | (ovf & ~bus.clr_err);
      unf <= unf_set | (unf & ~bus.clr_err);
    end
  end
  assign bus.level_a = stk[0];
  assign bus.level_b = stk[1];
  assign bus.count   = cnt;
  assign bus.empty   = cnt == '0;
  assign bus.full    = full;
  assign bus.ovf     = ovf;
  assign bus.unf     = unf;
endmodule

// File: tb/tb_hc4_operand_stack.sv
// tb_hc4_operand_stack: directed checks of a shift-mode and a reject-mode stack driven in lockstep.
module tb_hc4_operand_stack;
  import hc4_operand_stack_pkg::*;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  int errors = 0;
  int checks = 0;
  hc4_operand_stack_if #(.WIDTH(4), .DEPTH(8)) bs ();
  hc4_operand_stack_if #(.WIDTH(4), .DEPTH(8)) br ();
  hc4_operand_stack #(.WIDTH(4), .DEPTH(8), .SHIFT_MODE(1'b1)) dut_s (.clk(clk), .Reset(Reset), .bus(bs));
  hc4_operand_stack #(.WIDTH(4), .DEPTH(8), .SHIFT_MODE(1'b0)) dut_r (.clk(clk), .Reset(Reset), .bus(br));
  always #5 clk = ~clk;

  task automatic do_op(input op_e o, input logic [3:0] d, input logic c);
    bs.op = o; br.op = o; bs.din = d; br.din = d; bs.clr_err = c; br.clr_err = c;
    @(posedge clk); #1;
    bs.op = OP_NOP; br.op = OP_NOP; bs.clr_err = 1'b0; br.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bs.op = OP_NOP; br.op = OP_NOP; bs.clr_err = 1'b0; br.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    do_op(OP_NOP, 4'd0, 1'b0);
    checks++; if (bs.level_a !== 4'd0) begin errors++; $display("FAIL reset_level_a got %0d exp 0", bs.level_a); end
    checks++; if (bs.level_b !== 4'd0) begin errors++; $display("FAIL reset_level_b got %0d exp 0", bs.level_b); end
    checks++; if (bs.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bs.count); end
    checks++; if (bs.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", bs.empty); end
    checks++; if (bs.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", bs.full); end
    checks++; if ({bs.ovf, bs.unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bs.ovf, bs.unf}); end
  endtask

  task automatic test_swap_poprepl();
    do_reset();
    do_op(OP_PUSH, 4'd3, 1'b0);
    do_op(OP_PUSH, 4'd5, 1'b0);
    checks++; if (bs.level_a !== 4'd5) begin errors++; $display("FAIL push_level_a got %0d exp 5", bs.level_a); end
    do_op(OP_SWAP, 4'd0, 1'b0);
    checks++; if ({bs.level_a, bs.level_b} !== {4'd3, 4'd5}) begin errors++; $display("FAIL swap_levels got %h exp 35", {bs.level_a, bs.level_b}); end
    checks++; if (bs.count !== 4'd2) begin errors++; $display("FAIL swap_count got %0d exp 2", bs.count); end
    do_op(OP_POPREPL, 4'd8, 1'b0);
    checks++; if ({bs.level_a, bs.level_b} !== {4'd8, 4'd0}) begin errors++; $display("FAIL poprepl_levels got %h exp 80", {bs.level_a, bs.level_b}); end
    checks++; if (bs.count !== 4'd1) begin errors++; $display("FAIL poprepl_count got %0d exp 1", bs.count); end
    do_op(OP_DUP, 4'd0, 1'b0);
    checks++; if ({bs.level_a, bs.level_b, bs.count} !== {4'd8, 4'd8, 4'd2}) begin errors++; $display("FAIL dup got %h exp 882", {bs.level_a, bs.level_b, bs.count}); end
    do_op(OP_REPL, 4'd6, 1'b0);
    checks++; if ({bs.level_a, bs.level_b, bs.unf} !== {4'd6, 4'd8, 1'b0}) begin errors++; $display("FAIL repl got %h exp 6,8,0", {bs.level_a, bs.level_b, bs.unf}); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 1; k <= 9; k++) do_op(OP_PUSH, 4'(k), 1'b0);
    checks++; if ({bs.count, bs.full, bs.ovf} !== {4'd8, 1'b1, 1'b0}) begin errors++; $display("FAIL shift_full got cnt=%0d full=%0b ovf=%0b exp 8 1 0", bs.count, bs.full, bs.ovf); end
    checks++; if ({bs.level_a, bs.level_b} !== {4'd9, 4'd8}) begin errors++; $display("FAIL shift_top got %h exp 98", {bs.level_a, bs.level_b}); end
    checks++; if ({br.level_a, br.level_b, br.count} !== {4'd8, 4'd7, 4'd8}) begin errors++; $display("FAIL reject_top got %h exp 878", {br.level_a, br.level_b, br.count}); end
    checks++; if (br.ovf !== 1'b1) begin errors++; $display("FAIL reject_ovf got %0b exp 1", br.ovf); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (bs.level_a !== 4'(9 - k)) begin errors++; $display("FAIL shift_pop%0d got %0d exp %0d", k, bs.level_a, 9 - k); end
      do_op(OP_POP, 4'd0, 1'b0);
    end
    checks++; if ({bs.empty, bs.level_a, bs.unf} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL shift_drained got %h exp 100", {bs.empty, bs.level_a, bs.unf}); end
    checks++; if (br.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", br.ovf); end
    do_op(OP_NOP, 4'd0, 1'b1);
    checks++; if (br.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", br.ovf); end
  endtask

  task automatic test_underflow();
    do_reset();
    do_op(OP_POP, 4'd0, 1'b0);
    checks++; if ({bs.unf, bs.count, bs.empty} !== {1'b1, 4'd0, 1'b1}) begin errors++; $display("FAIL pop_empty got %h exp 1,0,1", {bs.unf, bs.count, bs.empty}); end
    do_op(OP_NOP, 4'd0, 1'b1);
    checks++; if (bs.unf !== 1'b0) begin errors++; $display("FAIL unf_clear got %0b exp 0", bs.unf); end
    do_op(OP_DUP, 4'd0, 1'b0);
    checks++; if ({bs.unf, bs.count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL dup_empty got %h exp 1,0", {bs.unf, bs.count}); end
    do_op(OP_NOP, 4'd0, 1'b1);
    do_op(OP_PUSH, 4'd7, 1'b0);
    do_op(OP_SWAP, 4'd0, 1'b0);
    checks++; if ({bs.unf, bs.level_a, bs.level_b, bs.count} !== {1'b1, 4'd7, 4'd0, 4'd1}) begin errors++; $display("FAIL swap_one got %h exp 1,7,0,1", {bs.unf, bs.level_a, bs.level_b, bs.count}); end
    do_op(OP_POPREPL, 4'd2, 1'b1);
    checks++; if ({bs.unf, bs.level_a, bs.count} !== {1'b1, 4'd7, 4'd1}) begin errors++; $display("FAIL poprepl_one got %h exp 1,7,1", {bs.unf, bs.level_a, bs.count}); end
    do_op(OP_NOP, 4'd0, 1'b1);
    do_op(OP_POP, 4'd0, 1'b0);
    do_op(OP_REPL, 4'd4, 1'b0);
    checks++; if ({bs.unf, bs.level_a, bs.count} !== {1'b1, 4'd0, 4'd0}) begin errors++; $display("FAIL repl_empty got %h exp 1,0,0", {bs.unf, bs.level_a, bs.count}); end
    do_op(OP_NOP, 4'd0, 1'b1);
    do_op(OP_RSVD, 4'd9, 1'b0);
    checks++; if ({bs.unf, bs.ovf, bs.count} !== {1'b0, 1'b0, 4'd0}) begin errors++; $display("FAIL op7_nop got %h exp 0,0,0", {bs.unf, bs.ovf, bs.count}); end
    do_op(OP_POP, 4'd0, 1'b0);
    do_op(OP_POP, 4'd0, 1'b1);
    checks++; if (bs.unf !== 1'b1) begin errors++; $display("FAIL clr_vs_fault got %0b exp 1", bs.unf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 5; k++) do_op(OP_PUSH, 4'(k), 1'b0);
    checks++; if (bs.count !== 4'd5) begin errors++; $display("FAIL mid_count got %0d exp 5", bs.count); end
    Reset = 1'b1; bs.op = OP_PUSH; br.op = OP_PUSH; bs.din = 4'd6; br.din = 4'd6;
    @(posedge clk); #1;
    Reset = 1'b0; bs.op = OP_NOP; br.op = OP_NOP;
    checks++; if ({bs.count, bs.level_a, bs.level_b, bs.empty} !== {4'd0, 4'd0, 4'd0, 1'b1}) begin errors++; $display("FAIL mid_reset got %h exp 0,0,0,1", {bs.count, bs.level_a, bs.level_b, bs.empty}); end
  endtask

  initial begin
    bs.op = OP_NOP; br.op = OP_NOP; bs.din = '0; br.din = '0; bs.clr_err = 1'b0; br.clr_err = 1'b0;
    test_reset();
    test_swap_poprepl();
    test_full();
    test_underflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
